clock_cell_div_bank: RTL and testbench

- Bank of CHANNELS independent programmable clock dividers, all running from one source clock.
- Each channel produces two outputs:
  - a registered, glitch-free divided clock;
  - a one-cycle clock-enable pulse, aligned to the end of each period.
- Ratio changes go through a valid/ready handshake and take effect only at a period boundary. Start and stop are glitch-free.
- Sits in the clock logistic layer, between the root clock buffers/muxes and the per-domain gate cells.

---
 rtl/clock_cell_div_bank.sv | 75 +++++++
 tb/tb_clock_cell_div_bank.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/clock_cell_div_bank.sv
// clock_cell_div_bank: bank of independent glitch-free programmable clock dividers with enable pulses
// Ratio updates are staged in a one-deep pending slot and applied only on a period boundary.
module clock_cell_div_bank #(
    parameter int CHANNELS  = 4,
    parameter int DIV_W     = 8,
    parameter int DEF_RATIO = 2
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic [CHANNELS*DIV_W-1:0] cfg_ratio,
    input  logic [CHANNELS-1:0]       cfg_valid,
    output logic [CHANNELS-1:0]       cfg_ready,
    output logic [CHANNELS-1:0]       cfg_done,
    output logic [CHANNELS-1:0]       clk_div,
    output logic [CHANNELS-1:0]       clk_en,
    output logic [CHANNELS-1:0]       ch_active
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam logic [DIV_W-1:0] DEF = DIV_W'(DEF_RATIO);
    localparam logic [DIV_W-1:0] MIN = DIV_W'(2);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state, n_state;
        logic [DIV_W-1:0] cnt, ratio, pend, n_cnt, n_ratio, req;
        logic             run, wrap, apply, take, n_run;
        logic             rdy, done, div, en, act;

        assign cfg_ready[i] = rdy;
        assign cfg_done[i]  = done;
        assign clk_div[i]   = div;
        assign clk_en[i]    = en;
        assign ch_active[i] = act;

        // A stop request is honoured only on the wrap cycle, so the last period always completes.
        always_comb begin
            req     = cfg_ratio[i*DIV_W +: DIV_W];
            run     = state != IDLE;
            wrap    = cnt == ratio - 1'b1;
            apply   = !rdy && (!run || wrap);
            take    = cfg_valid[i] && rdy;
            n_ratio = apply ? pend : ratio;
            n_state = !run ? (ch_en[i] ? RUN : IDLE) :
                      (wrap && !ch_en[i]) ? IDLE : (ch_en[i] ? RUN : DRAIN);
            n_run   = n_state != IDLE;
            n_cnt   = (!run || wrap) ? '0 : cnt + 1'b1;
        end

        // Outputs are registered from next-state values so they change only on ck.
        always_ff @(posedge ck or posedge rst) begin
            if (rst) begin
                state <= IDLE;
                cnt   <= '0;
                ratio <= DEF;
                pend  <= DEF;
                rdy   <= 1'b1;
                done  <= 1'b0;
                div   <= 1'b0;
                en    <= 1'b0;
                act   <= 1'b0;
            end else begin
                state <= n_state;
                cnt   <= n_cnt;
                ratio <= n_ratio;
                if (take)
                    pend <= (req < MIN) ? MIN : req;
                rdy   <= rdy ? !take : apply;
                done  <= apply;
                div   <= n_run && (n_cnt < n_ratio - (n_ratio >> 1));
                en    <= n_run && (n_cnt == n_ratio - 1'b1);
                act   <= n_run;
            end
        end
    end
endmodule

// File: tb/tb_clock_cell_div_bank.sv
// tb_clock_cell_div_bank: directed and random stimulus, per-cycle scoreboard against a period-level model.
module tb_clock_cell_div_bank;
    localparam int CH = 4;
    localparam int W  = 8;

    logic            ck = 1'b0;
    logic            rst;
    logic [CH-1:0]   ch_en, cfg_valid;
    logic [CH*W-1:0] cfg_ratio;
    logic [CH-1:0]   cfg_ready, cfg_done, clk_div, clk_en, ch_active;

    clock_cell_div_bank #(.CHANNELS(CH), .DIV_W(W), .DEF_RATIO(2)) dut (
        .ck(ck), .rst(rst), .ch_en(ch_en), .cfg_ratio(cfg_ratio), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done), .clk_div(clk_div), .clk_en(clk_en),
        .ch_active(ch_active)
    );

    always #5 ck = ~ck;

    localparam logic [5*CH-1:0] RST_EXP = {{(3*CH){1'b0}}, {CH{1'b1}}, {CH{1'b0}}};

    int checks = 0;
    int errors = 0;
    logic [5*CH-1:0] exp_q[$];

    // Model: position within the current period, active ratio, pending ratio (0 = empty).
    int m_act[CH], m_pos[CH], m_r[CH], m_pend[CH], m_done[CH];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_act[c] = 0; m_pos[c] = 0; m_r[c] = 2; m_pend[c] = 0; m_done[c] = 0;
        end
    endtask

    task automatic model_step();
        logic [CH-1:0] e_div, e_en, e_done, e_rdy, e_act;
        if (rst) model_reset();
        else for (int c = 0; c < CH; c++) begin
            int r;
            bit was_empty;
            was_empty = m_pend[c] == 0;
            m_done[c] = 0;
            if (!m_act[c]) begin
                if (m_pend[c] != 0) begin m_r[c] = m_pend[c]; m_pend[c] = 0; m_done[c] = 1; end
                if (ch_en[c]) begin m_act[c] = 1; m_pos[c] = 0; end
            end else if (m_pos[c] == m_r[c] - 1) begin
                if (m_pend[c] != 0) begin m_r[c] = m_pend[c]; m_pend[c] = 0; m_done[c] = 1; end
                m_pos[c] = 0;
                if (!ch_en[c]) m_act[c] = 0;
            end else m_pos[c]++;
            if (cfg_valid[c] && was_empty) begin
                r = int'(cfg_ratio[c*W +: W]);
                m_pend[c] = (r < 2) ? 2 : r;
            end
        end
        for (int c = 0; c < CH; c++) begin
            e_div[c]  = m_act[c] != 0 && m_pos[c] < (m_r[c] + 1) / 2;
            e_en[c]   = m_act[c] != 0 && m_pos[c] == m_r[c] - 1;
            e_done[c] = m_done[c] != 0;
            e_rdy[c]  = m_pend[c] == 0;
            e_act[c]  = m_act[c] != 0;
        end
        exp_q.push_back({e_div, e_en, e_done, e_rdy, e_act});
    endtask

    task automatic cyc();
        @(posedge ck);
        #1;
        model_step();
    endtask

    task automatic load(int c, int r);
        cfg_valid[c] = 1'b1;
        cfg_ratio[c*W +: W] = W'(r);
        cyc();
        cfg_valid[c] = 1'b0;
    endtask

    task automatic wait_pos(int c, int p);
        int n = 0;
        while (!(m_act[c] != 0 && m_pos[c] == p) && n < 600) begin cyc(); n++; end
        if (n == 600) begin
            $display("FAIL wait_pos ch%0d pos %0d not reached within 600 cycles", c, p);
            $fatal(1);
        end
    endtask

    initial begin
        logic [5*CH-1:0] e, a;
        forever begin
            @(negedge ck);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {clk_div, clk_en, cfg_done, cfg_ready, ch_active};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t div/en/done/rdy/act act=%h exp=%h", $time, a, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; ch_en = '0; cfg_valid = '0; cfg_ratio = '0;
        model_reset();
        repeat (2) cyc();
        rst = 1'b0;
        repeat (3) cyc();
        ch_en[0] = 1'b1;
        repeat (8) cyc();
        load(1, 5); repeat (2) cyc();
        ch_en[1] = 1'b1; repeat (12) cyc();
        load(2, 0); cyc();
        ch_en[2] = 1'b1; repeat (8) cyc();
        load(3, 4); cyc();
        ch_en[3] = 1'b1;
        wait_pos(3, 1); load(3, 6); repeat (16) cyc();
        load(0, 8);
        wait_pos(0, 2); ch_en[0] = 1'b0; repeat (8) cyc();
        ch_en[0] = 1'b1; repeat (12) cyc();
        wait_pos(0, 2); ch_en[0] = 1'b0;
        wait_pos(0, 5); ch_en[0] = 1'b1; repeat (20) cyc();
        // Asynchronous reset mid-period: outputs must clear before the next rising edge.
        wait_pos(0, 1);
        #1 rst = 1'b1;
        model_reset();
        void'(exp_q.pop_back());
        exp_q.push_back(RST_EXP);
        cyc();
        rst = 1'b0;
        repeat (3000) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 19) == 0) ch_en[c] = ~ch_en[c];
                cfg_valid[c] = $urandom_range(0, 3) == 0;
                cfg_ratio[c*W +: W] = ($urandom_range(0, 99) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
            end
            cyc();
        end
        cfg_valid = '0;
        repeat (3) cyc();
        @(negedge ck);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
